uart_baud_autocfg: RTL and testbench
====================================

Name: uart_baud_autocfg

Overview:
- Configuration controller for the UART 16x baud-tick generator: drives its 13-bit `baud_val` and 3-bit `baud_val_fraction` inputs.
- In auto mode it measures a received 0x55 sync character on `rx` and derives divider and fraction from the measured 8-bit-time interval.
- In manual mode it loads software values.
- Sits between the APB register file and the baud generator; `locked` gates the receiver and transmitter enables.

Parameters:
- CNT_W, 20, measurement counter width; fixed at 20 so that T[19:7] maps onto the 13-bit `baud_val`.
- DEFAULT_BAUD_VAL, 13'd26, `baud_val` after reset.
- DEFAULT_FRACTION, 3'd1, `baud_val_fraction` after reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- rx  in  1  asynchronous serial input (idle high)
- start  in  1  one-cycle pulse: arm auto-baud measurement
- sw_load  in  1  one-cycle pulse: load sw_baud_val and sw_fraction
- sw_baud_val  in  13  software divider value
- sw_fraction  in  3  software fraction value
- baud_val  out  13  divider to baud generator
- baud_val_fraction  out  3  fraction to baud generator
- busy  out  1  measurement in progress
- locked  out  1  outputs hold a valid configuration
- done  out  1  one-cycle pulse when a measurement ends (success or error)
- err  out  2  00 ok, 01 out of range, 10 timeout, 11 pattern mismatch

Behaviour:
- Reset and clock: reset_n is asynchronous, active-low; clock is clk.
- Reset values: `baud_val` = DEFAULT_BAUD_VAL, `baud_val_fraction` = DEFAULT_FRACTION, `busy` = 0, `locked` = 0, `done` = 0, `err` = 00, FSM = IDLE, counters = 0.
- rx synchronisation: 2-flop synchroniser (reset value 1), then a registered falling-edge detect. A pin edge is seen as `fe` 3 cycles later. The fixed delay cancels in interval measurement.
- FSM states:
  - IDLE: `start` → WAIT_E0, `busy` = 1, `err` cleared.
  - WAIT_E0: on `fe`, clear cnt, clear edge_cnt, → MEASURE. Otherwise cnt increments; saturation → FAIL(10).
  - MEASURE: cnt increments every cycle. On `fe`, edge_cnt increments:
    - at edge_cnt 1, capture T1 = cnt+1 (2 bit times);
    - at edge_cnt 4, capture T = cnt+1 (8 bit times) → CALC.
    - cnt reaching all-ones → FAIL(10).
  - CALC (1 cycle):
    - if T[19:7] == 0 or T[19:7] > 8191 → FAIL(01);
    - else if |T − 4·T1| > T1/2 → FAIL(11);
    - else commit `baud_val` = T[19:7] − 1 and `baud_val_fraction` = T[6:4], set `locked` = 1, `done` = 1 → IDLE.
  - FAIL: set `err`, `done` = 1, `locked` = 0; `baud_val` and `baud_val_fraction` are unchanged → IDLE.
- `busy` = 1 in WAIT_E0, MEASURE and CALC.
- Latency: outputs update on the clock edge ending CALC, which is 2 cycles after the 5th `fe`.
- `sw_load`:
  - in any state: `baud_val` ← sw_baud_val, `baud_val_fraction` ← sw_fraction, `locked` = 1, `err` = 00, FSM → IDLE next cycle (aborts a measurement without a `done` pulse);
  - with `start` in the same cycle: `sw_load` wins and `start` is ignored.
- `start` while `busy` is ignored.
- `start` clears `locked` on acceptance.
- Outputs change only on commit or `sw_load`; they never glitch during measurement.
- Arithmetic: T1 is 18 bits; 4·T1 and the difference use CNT_W+1 bits; no wrap, because the counter saturates.
- Reset asserted mid-measurement returns everything to reset values immediately.

Test Plan:
- 50 MHz, bit time 434 clk, 0x55 on rx after `start` → T = 3472, `baud_val` = 26, `baud_val_fraction` = 1, `locked` = 1, `done` pulse, `err` = 00.
- Bit time 5208 clk (9600 baud) → T = 41664, `baud_val` = 324, `baud_val_fraction` = 4, `locked` = 1.
- Bit time 10 clk → T = 80, `err` = 01, `locked` = 0, `baud_val` and `baud_val_fraction` unchanged, `done` pulse.
- `start` with rx held high for 2^20 cycles → `err` = 10, `done` pulse, `busy` falls.
- First low interval 434 clk, remaining bits 868 clk → `err` = 11; separately, `sw_load` (sw_baud_val = 100, sw_fraction = 7) mid-MEASURE → outputs 100/7 next cycle, `locked` = 1, `busy` = 0, no `done` pulse.
- `start` and `sw_load` asserted in the same cycle → load applied, FSM stays IDLE.
- reset_n pulsed mid-MEASURE → all outputs return to reset values.

Source files
------------

// File: rtl/uart_baud_autocfg.sv
// Auto-baud configuration for the UART 16x tick generator: measures a 0x55 sync
// character on rx to derive baud_val/baud_val_fraction, or takes software values.
//
// state   | meaning
// IDLE    | holding current configuration, waiting for start
// WAIT_E0 | armed, waiting for the start-bit falling edge
// MEASURE | counting cycles across the next four falling edges
// CALC    | range and pattern checks, commit on success
// FAIL    | report error code, drop locked
module uart_baud_autocfg #(
  parameter int unsigned CNT_W            = 20,
  parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd26,
  parameter logic [2:0]  DEFAULT_FRACTION = 3'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic        start,
  input  logic        sw_load,
  input  logic [12:0] sw_baud_val,
  input  logic [2:0]  sw_fraction,
  output logic [12:0] baud_val,
  output logic [2:0]  baud_val_fraction,
  output logic        busy,
  output logic        locked,
  output logic        done,
  output logic [1:0]  err
);

  localparam int unsigned T1_W = CNT_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_E0,
    S_MEASURE,
    S_CALC,
    S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic              rx_s1_q, rx_s1_d;
  logic              rx_s2_q, rx_s2_d;
  logic              rx_prev_q, rx_prev_d;
  logic              fe_q, fe_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        edge_cnt_q, edge_cnt_d;
  logic [T1_W-1:0]   t1_q, t1_d;
  logic [CNT_W-1:0]  t_q, t_d;
  logic [1:0]        fail_code_q, fail_code_d;
  logic [12:0]       baud_val_q, baud_val_d;
  logic [2:0]        fraction_q, fraction_d;
  logic              locked_q, locked_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic              cnt_sat;
  logic [CNT_W-1:0]  t_hi;
  logic [31:0]       t_hi_ext;
  logic [CNT_W:0]    t_ext, t1_x4, t_diff, t1_half;

  always_comb begin
    rx_s1_d   = rx;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    fe_d      = rx_prev_q & ~rx_s2_q;
  end

  // Counter saturates instead of wrapping, so the signed difference below never aliases.
  assign cnt_inc  = cnt_q + 1'b1;
  assign cnt_sat  = &cnt_q;
  assign t_hi     = t_q >> 7;
  assign t_hi_ext = 32'(t_hi);
  assign t_ext    = {1'b0, t_q};
  assign t1_x4    = {1'b0, t1_q, 2'b00};
  assign t_diff   = (t_ext >= t1_x4) ? (t_ext - t1_x4) : (t1_x4 - t_ext);
  assign t1_half  = (CNT_W+1)'(t1_q >> 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_cnt_d  = edge_cnt_q;
    t1_d        = t1_q;
    t_d         = t_q;
    fail_code_d = fail_code_q;
    baud_val_d  = baud_val_q;
    fraction_d  = fraction_q;
    locked_d    = locked_q;
    err_d       = err_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WAIT_E0;
          cnt_d    = '0;
          err_d    = 2'b00;
          locked_d = 1'b0;
        end
      end
      S_WAIT_E0: begin
        if (fe_q) begin
          cnt_d      = '0;
          edge_cnt_d = '0;
          state_d    = S_MEASURE;
        end else if (cnt_sat) begin
          fail_code_d = 2'b10;
          state_d     = S_FAIL;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEASURE: begin
        if (cnt_sat) begin
          fail_code_d = 2'b10;
          state_d     = S_FAIL;
        end else begin
          cnt_d = cnt_inc;
          if (fe_q) begin
            edge_cnt_d = edge_cnt_q + 3'd1;
            if (edge_cnt_q == 3'd0) begin
              t1_d = T1_W'(cnt_inc);
            end
            if (edge_cnt_q == 3'd3) begin
              t_d     = cnt_inc;
              state_d = S_CALC;
            end
          end
        end
      end
      S_CALC: begin
        if (t_hi_ext == 32'd0 || t_hi_ext > 32'd8191) begin
          fail_code_d = 2'b01;
          state_d     = S_FAIL;
        end else if (t_diff > t1_half) begin
          fail_code_d = 2'b11;
          state_d     = S_FAIL;
        end else begin
          baud_val_d = 13'(t_hi - 1'b1);
          fraction_d = t_q[6:4];
          locked_d   = 1'b1;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_FAIL: begin
        err_d    = fail_code_q;
        done_d   = 1'b1;
        locked_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Software load overrides everything, including a start in the same cycle.
    if (sw_load) begin
      baud_val_d = sw_baud_val;
      fraction_d = sw_fraction;
      locked_d   = 1'b1;
      err_d      = 2'b00;
      done_d     = 1'b0;
      cnt_d      = '0;
      edge_cnt_d = '0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      fe_q        <= 1'b0;
      cnt_q       <= '0;
      edge_cnt_q  <= '0;
      t1_q        <= '0;
      t_q         <= '0;
      fail_code_q <= 2'b00;
      baud_val_q  <= DEFAULT_BAUD_VAL;
      fraction_q  <= DEFAULT_FRACTION;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      fe_q        <= fe_d;
      cnt_q       <= cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      t1_q        <= t1_d;
      t_q         <= t_d;
      fail_code_q <= fail_code_d;
      baud_val_q  <= baud_val_d;
      fraction_q  <= fraction_d;
      locked_q    <= locked_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy              = (state_q == S_WAIT_E0) || (state_q == S_MEASURE) || (state_q == S_CALC);
  assign baud_val          = baud_val_q;
  assign baud_val_fraction = fraction_q;
  assign locked            = locked_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_uart_baud_autocfg.sv
// Self-checking bench for uart_baud_autocfg: directed and randomized sync frames against an
// arithmetic reference model; a 12-bit-counter instance exercises the timeout path quickly.
`timescale 1ns/1ps
module tb_uart_baud_autocfg;

  typedef int dur_t [9];

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx;
  logic        start;
  logic        sw_load;
  logic [12:0] sw_baud_val;
  logic [2:0]  sw_fraction;

  logic [12:0] baud_val,   baud_val_s;
  logic [2:0]  frac,       frac_s;
  logic        busy,       busy_s;
  logic        locked,     locked_s;
  logic        done,       done_s;
  logic [1:0]  err,        err_s;

  int n_checks = 0;
  int n_errors = 0;
  int exp_bv = 26;
  int exp_fr = 1;
  int exp_lk = 0;

  uart_baud_autocfg u_dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .start(start), .sw_load(sw_load),
    .sw_baud_val(sw_baud_val), .sw_fraction(sw_fraction),
    .baud_val(baud_val), .baud_val_fraction(frac), .busy(busy),
    .locked(locked), .done(done), .err(err)
  );

  // Short counter so the timeout path completes in a few thousand cycles.
  uart_baud_autocfg #(.CNT_W(12)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .rx(rx), .start(start), .sw_load(sw_load),
    .sw_baud_val(sw_baud_val), .sw_fraction(sw_fraction),
    .baud_val(baud_val_s), .baud_val_fraction(frac_s), .busy(busy_s),
    .locked(locked_s), .done(done_s), .err(err_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Falls of a 0x55 frame sit at the starts of bits 0,2,4,6,8.
  task automatic ref_model(input dur_t dur, output int e_err, output int e_bv, output int e_fr);
    int t1, t, hi, diff;
    t1 = dur[0] + dur[1];
    t  = 0;
    for (int i = 0; i < 8; i++) t += dur[i];
    hi   = t / 128;
    diff = t - 4 * t1;
    if (diff < 0) diff = -diff;
    e_bv = 0;
    e_fr = 0;
    if (hi == 0 || hi > 8191) e_err = 1;
    else if (diff > t1 / 2) e_err = 3;
    else begin
      e_err = 0;
      e_bv  = hi - 1;
      e_fr  = (t / 16) % 8;
    end
  endtask

  task automatic run_frame(input string tag, input dur_t dur);
    int e_err, e_bv, e_fr, lat;
    bit seen;
    ref_model(dur, e_err, e_bv, e_fr);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_armed"}, int'(busy), 1);
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      rx = i[0];
      repeat (dur[i]) step();
    end
    rx   = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    rx = 1'b1;
    if (e_err == 0) begin
      exp_bv = e_bv;
      exp_fr = e_fr;
      exp_lk = 1;
    end else begin
      exp_lk = 0;
    end
    check({tag, "_latency"}, lat, (e_err == 0) ? 5 : 6);
    check({tag, "_err"}, int'(err), e_err);
    check({tag, "_baud_val"}, int'(baud_val), exp_bv);
    check({tag, "_fraction"}, int'(frac), exp_fr);
    check({tag, "_locked"}, int'(locked), exp_lk);
    check({tag, "_busy_end"}, int'(busy), 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, int'(done), 0);
    step();
  endtask

  initial begin
    dur_t d;
    int   dn, lat, b, mode, j, v;
    bit   seen;

    reset_n     = 1'b0;
    rx          = 1'b1;
    start       = 1'b0;
    sw_load     = 1'b0;
    sw_baud_val = '0;
    sw_fraction = '0;
    #12;
    check("rst_baud_val", int'(baud_val), 26);
    check("rst_fraction", int'(frac), 1);
    check("rst_locked", int'(locked), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_small_baud_val", int'(baud_val_s), 26);
    #11 reset_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) d[i] = 434;
    d[8] = 1;
    run_frame("b434", d);

    for (int i = 0; i < 9; i++) d[i] = 5208;
    d[8] = 1;
    run_frame("b5208", d);

    for (int i = 0; i < 9; i++) d[i] = 10;
    d[8] = 1;
    run_frame("b10_range", d);

    d[0] = 434;
    for (int i = 1; i < 9; i++) d[i] = 868;
    d[8] = 1;
    run_frame("pattern", d);

    for (int k = 0; k < 4; k++) begin
      b    = int'($urandom_range(200, 8));
      mode = int'($urandom_range(2, 0));
      j    = b / 16;
      for (int i = 0; i < 9; i++) begin
        v = b;
        if (mode == 1) v = b + int'($urandom_range(2 * j, 0)) - j;
        if (mode == 2 && i >= 2) v = b + int'($urandom_range(b, 0));
        d[i] = (v < 1) ? 1 : v;
      end
      d[8] = 1;
      run_frame($sformatf("rand%0d_b%0d_m%0d", k, b, mode), d);
    end

    // Software load in the middle of a measurement aborts it with no done pulse.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rx = 1'b0; repeat (434) step();
    rx = 1'b1; repeat (434) step();
    rx = 1'b0; repeat (434) step();
    rx = 1'b1; repeat (100) step();
    check("swl_busy_before", int'(busy), 1);
    sw_baud_val = 13'd100;
    sw_fraction = 3'd7;
    sw_load     = 1'b1;
    step();
    sw_load = 1'b0;
    exp_bv = 100; exp_fr = 7; exp_lk = 1;
    check("swl_baud_val", int'(baud_val), 100);
    check("swl_fraction", int'(frac), 7);
    check("swl_locked", int'(locked), 1);
    check("swl_busy", int'(busy), 0);
    check("swl_err", int'(err), 0);
    dn = 0;
    for (int c = 0; c < 1800; c++) begin
      if (c % 434 == 0) rx = ~rx;
      step();
      if (done) dn++;
    end
    rx = 1'b1;
    repeat (10) step();
    check("swl_no_done", dn, 0);

    // start and sw_load together: the load wins and the FSM stays idle.
    sw_baud_val = 13'd55;
    sw_fraction = 3'd3;
    sw_load     = 1'b1;
    start       = 1'b1;
    step();
    sw_load = 1'b0;
    start   = 1'b0;
    exp_bv = 55; exp_fr = 3; exp_lk = 1;
    check("both_baud_val", int'(baud_val), 55);
    check("both_fraction", int'(frac), 3);
    check("both_locked", int'(locked), 1);
    check("both_busy", int'(busy), 0);
    repeat (3) step();
    check("both_busy_later", int'(busy), 0);

    // Timeout on the 12-bit instance with rx held high.
    check("to_small_locked_before", int'(locked_s), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("to_small_busy", int'(busy_s), 1);
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < 4400 && !seen; c++) begin
      @(negedge clk);
      if (done_s) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("to_done_seen", int'(seen), 1);
    check("to_latency_window", int'(lat >= 4096 && lat <= 4098), 1);
    check("to_err", int'(err_s), 2);
    check("to_busy_fell", int'(busy_s), 0);
    check("to_locked", int'(locked_s), 0);
    check("to_baud_val_kept", int'(baud_val_s), 55);
    check("to_big_still_busy", int'(busy), 1);
    step();

    // Reset asserted while the main instance is in MEASURE.
    rx = 1'b0; repeat (50) step();
    rx = 1'b1; repeat (50) step();
    rx = 1'b0; repeat (20) step();
    check("mrst_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #2;
    check("mrst_baud_val", int'(baud_val), 26);
    check("mrst_fraction", int'(frac), 1);
    check("mrst_locked", int'(locked), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_err", int'(err), 0);
    rx = 1'b1;
    step();
    reset_n = 1'b1;
    repeat (5) step();
    check("mrst_idle_after", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
